calc_instr_encoder: RTL

Front-end instruction encoder for the `calculadora` datapath. It accepts decoded instruction fields through a valid/ready port and encodes them into RV32I machine words. The words are buffered in a small FIFO and emitted with a sequential write address, ready to be loaded into the calculator's instruction memory. It is the producing end of the instruction stream that `calculadora` consumes on each `opera` pulse.

---
 rtl/calc_isa_pkg.sv | 68 ++++++
 rtl/calc_instr_fifo.sv | 61 ++++++
 rtl/calc_instr_encoder.sv | 78 +++++++
 3 files changed

// File: rtl/calc_isa_pkg.sv
// rtl/calc_isa_pkg.sv - RV32I op map, opcode/funct constants and field encoder
package calc_isa_pkg;

    typedef enum logic [3:0] {
        OP_ADDI = 4'd0,
        OP_SLTI = 4'd1,
        OP_XORI = 4'd2,
        OP_ORI  = 4'd3,
        OP_ANDI = 4'd4,
        OP_ADD  = 4'd5,
        OP_SUB  = 4'd6,
        OP_SLT  = 4'd7,
        OP_XOR  = 4'd8,
        OP_OR   = 4'd9,
        OP_AND  = 4'd10,
        OP_LUI  = 4'd11
    } calc_op_e;

    localparam logic [6:0] OPC_IMM = 7'h13;
    localparam logic [6:0] OPC_REG = 7'h33;
    localparam logic [6:0] OPC_LUI = 7'h37;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_SUB  = 7'h20;

    typedef struct packed {
        logic        legal;
        logic [31:0] word;
    } enc_t;

    function automatic logic is_itype(input logic [3:0] op);
        return op <= 4'd4;
    endfunction

    // Unlisted ops (12..15) come back with legal = 0 and a zero word.
    function automatic enc_t encode(input logic [3:0]  op,
                                    input logic [4:0]  rd,
                                    input logic [4:0]  rs1,
                                    input logic [4:0]  rs2,
                                    input logic [19:0] imm);
        enc_t r;
        r.legal = 1'b1;
        r.word  = '0;
        case (calc_op_e'(op))
            OP_ADDI: r.word = {imm[11:0], rs1, F3_ADD, rd, OPC_IMM};
            OP_SLTI: r.word = {imm[11:0], rs1, F3_SLT, rd, OPC_IMM};
            OP_XORI: r.word = {imm[11:0], rs1, F3_XOR, rd, OPC_IMM};
            OP_ORI:  r.word = {imm[11:0], rs1, F3_OR,  rd, OPC_IMM};
            OP_ANDI: r.word = {imm[11:0], rs1, F3_AND, rd, OPC_IMM};
            OP_ADD:  r.word = {F7_BASE, rs2, rs1, F3_ADD, rd, OPC_REG};
            OP_SUB:  r.word = {F7_SUB,  rs2, rs1, F3_ADD, rd, OPC_REG};
            OP_SLT:  r.word = {F7_BASE, rs2, rs1, F3_SLT, rd, OPC_REG};
            OP_XOR:  r.word = {F7_BASE, rs2, rs1, F3_XOR, rd, OPC_REG};
            OP_OR:   r.word = {F7_BASE, rs2, rs1, F3_OR,  rd, OPC_REG};
            OP_AND:  r.word = {F7_BASE, rs2, rs1, F3_AND, rd, OPC_REG};
            OP_LUI:  r.word = {imm, rd, OPC_LUI};
            default: r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/calc_instr_fifo.sv
// rtl/calc_instr_fifo.sv - synchronous FIFO holding encoded instruction words
module calc_instr_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32,
    localparam int PW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // Push is gated on full alone, so a pop in the same cycle never frees a slot early.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);
    assign level = count;
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/calc_instr_encoder.sv
// rtl/calc_instr_encoder.sv - field-to-RV32I encoder with output FIFO; CALC_ENC_RANGE_CHECK_EN enables I-type immediate range check
module calc_instr_encoder
    import calc_isa_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 5,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [19:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic [LW-1:0]     level,
    output logic              err
);

    enc_t enc;
    logic range_ok;
    logic accept;
    logic push;
    logic pop;
    logic full;
    logic empty;

    assign enc = encode(in_op, in_rd, in_rs1, in_rs2, in_imm);

`ifdef CALC_ENC_RANGE_CHECK_EN
    // I-type immediates must be the sign extension of a 12-bit value.
    assign range_ok = !is_itype(in_op) || (in_imm[19:11] == {9{in_imm[11]}});
`else
    assign range_ok = 1'b1;
`endif

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign accept    = in_valid && in_ready;
    assign push      = accept && enc.legal && range_ok;
    assign pop       = out_valid && out_ready;

    calc_instr_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(32)
    ) u_fifo (
        .clock(clock),
        .reset(reset),
        .push (push),
        .wdata(enc.word),
        .pop  (pop),
        .rdata(out_instr),
        .full (full),
        .empty(empty),
        .level(level)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            err      <= 1'b0;
            out_addr <= '0;
        end else begin
            if (accept && !(enc.legal && range_ok)) begin
                err <= 1'b1;
            end
            if (pop) begin
                out_addr <= out_addr + ADDR_W'(1);
            end
        end
    end

endmodule
